keypad_sense_debounce: RTL

Parametrised keypad column sense block: synchronises WIDTH active-low column pins, decodes them to one-hot, and debounces press/release with a counter FSM. It produces a stable one-hot key vector plus single-cycle press/release strobes. It sits between the raw column pins and the keypad scan FSM, and generalises the existing fixed 4-bit direct/2-flop readers in width, synchroniser depth and debounce.

---
 rtl/keypad_sense_debounce.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/keypad_sense_debounce.sv
// Keypad column sense: synchronises active-low column pins, decodes them to one-hot and debounces press/release.
// Optional auto-repeat of press_pulse while a key stays held is built when KEY_REPEAT_EN is defined.
module keypad_sense_debounce #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] sense,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             multi,
  output logic             busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
  logic [WIDTH-1:0] s, low, d;
  logic             one_low, multi_low, cand_low;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] cand_reg, cand_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [WIDTH-1:0] sense_reg, sense_next;
  logic             press_reg, press_next;
  logic             release_reg, release_next;
  logic             multi_reg;
  logic             busy_reg;

`ifdef KEY_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  logic [REP_W-1:0] rep_reg, rep_next, rep_inc, rep_target;
  logic             armed_reg, armed_next;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '1;
    end else begin
      sync_reg[0] <= pin;
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
    end
  end

  // low & (low-1) clears the lowest set bit: zero means at most one key is down.
  always_comb begin
    s         = sync_reg[SYNC_STAGES-1];
    low       = ~s;
    multi_low = (low & (low - 1'b1)) != '0;
    one_low   = (low != '0) && !multi_low;
    d         = one_low ? low : '0;
    cand_low  = (low & cand_reg) != '0;
    cnt_inc   = cnt_reg + 1'b1;
  end

  always_comb begin
    state_next   = state_reg;
    cand_next    = cand_reg;
    cnt_next     = cnt_reg;
    sense_next   = sense_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_next     = rep_reg;
    armed_next   = armed_reg;
    rep_inc      = rep_reg + 1'b1;
    rep_target   = armed_reg ? REP_W'(REPEAT_PERIOD) : REP_W'(REPEAT_DELAY);
`endif
    case (state_reg)
      IDLE: begin
        if (d != '0) begin
          cand_next = d;
          cnt_next  = CNT_ONE;
          if (DEBOUNCE_CYCLES == 1) begin
            state_next = HELD;
            sense_next = d;
            press_next = 1'b1;
`ifdef KEY_REPEAT_EN
            rep_next   = '0;
            armed_next = 1'b0;
`endif
          end else begin
            state_next = PRESS_WAIT;
          end
        end
      end
      PRESS_WAIT: begin
        if (d != cand_reg) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == DEB_MAX) begin
            state_next = HELD;
            sense_next = cand_reg;
            press_next = 1'b1;
`ifdef KEY_REPEAT_EN
            rep_next   = '0;
            armed_next = 1'b0;
`endif
          end
        end
      end
      HELD: begin
        if (!cand_low) begin
          cnt_next = CNT_ONE;
          if (DEBOUNCE_CYCLES == 1) begin
            state_next   = IDLE;
            sense_next   = '0;
            release_next = 1'b1;
            cnt_next     = '0;
`ifdef KEY_REPEAT_EN
            rep_next     = '0;
            armed_next   = 1'b0;
`endif
          end else begin
            state_next = RELEASE_WAIT;
          end
        end else begin
`ifdef KEY_REPEAT_EN
          if (rep_inc == rep_target) begin
            press_next = 1'b1;
            rep_next   = '0;
            armed_next = 1'b1;
          end else begin
            rep_next = rep_inc;
          end
`endif
        end
      end
      RELEASE_WAIT: begin
        // Repeat counter is deliberately left untouched here so a glitch resumes it.
        if (cand_low) begin
          state_next = HELD;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == DEB_MAX) begin
            state_next   = IDLE;
            sense_next   = '0;
            release_next = 1'b1;
            cnt_next     = '0;
`ifdef KEY_REPEAT_EN
            rep_next     = '0;
            armed_next   = 1'b0;
`endif
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cand_reg    <= '0;
      cnt_reg     <= '0;
      sense_reg   <= '0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      multi_reg   <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cand_reg    <= cand_next;
      cnt_reg     <= cnt_next;
      sense_reg   <= sense_next;
      press_reg   <= press_next;
      release_reg <= release_next;
      multi_reg   <= multi_low;
      busy_reg    <= (state_next != IDLE);
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      rep_reg   <= '0;
      armed_reg <= 1'b0;
    end else begin
      rep_reg   <= rep_next;
      armed_reg <= armed_next;
    end
  end
`endif

  assign sense         = sense_reg;
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;
  assign multi         = multi_reg;
  assign busy          = busy_reg;

endmodule
